// File: rtl/lfu_finder_param.sv
// Least-frequently-used victim finder with saturating per-buffer counters, aging and a registered victim.
// Optional macro LFU_LOCK_EN adds a lock_mask input that removes buffers from the victim search.
module lfu_finder_param #(
  parameter int NUM_BUF = 4,
  parameter int IDX_W   = $clog2(NUM_BUF),
  parameter int CNT_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ref_vld,
  input  logic [IDX_W-1:0]         ref_buf_numbr,
  input  logic                     new_buf_req,
  output logic [IDX_W-1:0]         buf_num_replc,
  output logic                     replc_vld,
  output logic                     aging_pulse,
  output logic [NUM_BUF*CNT_W-1:0] cnt_flat
`ifdef LFU_LOCK_EN
  ,
  input  logic [NUM_BUF-1:0]       lock_mask
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // A saturated buffer restarts just above the halved population after aging.
  localparam logic [CNT_W-1:0] CNT_AGED = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_NEW  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt     [NUM_BUF];
  logic [CNT_W-1:0] cnt_nxt [NUM_BUF];
  logic [NUM_BUF-1:0] eligible;
  logic [IDX_W-1:0]   victim;
  logic [CNT_W-1:0]   min_cnt;
  logic               victim_found;
  logic               do_repl;
  logic               ref_apply;
  logic               do_aging;

`ifdef LFU_LOCK_EN
  assign eligible = ~lock_mask;
`else
  assign eligible = '1;
`endif

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    victim       = '0;
    min_cnt      = '1;
    victim_found = 1'b0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (eligible[i] && (!victim_found || cnt[i] < min_cnt)) begin
        victim       = IDX_W'(i);
        min_cnt      = cnt[i];
        victim_found = 1'b1;
      end
    end
  end

  assign do_repl   = new_buf_req && victim_found;
  assign ref_apply = ref_vld && !(do_repl && (ref_buf_numbr == victim));
  assign do_aging  = ref_apply && (cnt[ref_buf_numbr] == CNT_MAX);

  // Reference update first, then the replacement overrides the victim slot.
  always_comb begin
    for (int j = 0; j < NUM_BUF; j++) begin
      cnt_nxt[j] = cnt[j];
      if (do_aging) begin
        if (IDX_W'(j) == ref_buf_numbr) cnt_nxt[j] = CNT_AGED;
        else                            cnt_nxt[j] = cnt[j] >> 1;
      end else if (ref_apply && (IDX_W'(j) == ref_buf_numbr)) begin
        cnt_nxt[j] = cnt[j] + CNT_NEW;
      end
      if (do_repl && (IDX_W'(j) == victim)) cnt_nxt[j] = CNT_NEW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BUF; k++) cnt[k] <= '0;
      buf_num_replc <= '0;
      replc_vld     <= 1'b0;
      aging_pulse   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_BUF; k++) cnt[k] <= cnt_nxt[k];
      if (do_repl) buf_num_replc <= victim;
      replc_vld   <= do_repl;
      aging_pulse <= do_aging;
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < NUM_BUF; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
  end

endmodule

// File: tb/tb_lfu_finder_param.sv
// Bench for lfu_finder_param (NUM_BUF=4, CNT_W=2): reference model plus a queue of expected victims.
module tb_lfu_finder_param;
  localparam int NUM_BUF = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 2;
  localparam int MAXV    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ref_vld = 1'b0;
  logic [IDX_W-1:0] ref_buf_numbr = '0;
  logic new_buf_req = 1'b0;
  logic [NUM_BUF-1:0] lock_mask = '0;
  logic [IDX_W-1:0] buf_num_replc;
  logic replc_vld;
  logic aging_pulse;
  logic [NUM_BUF*CNT_W-1:0] cnt_flat;

  lfu_finder_param #(.NUM_BUF(NUM_BUF), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ref_vld(ref_vld), .ref_buf_numbr(ref_buf_numbr),
    .new_buf_req(new_buf_req), .buf_num_replc(buf_num_replc), .replc_vld(replc_vld),
    .aging_pulse(aging_pulse), .cnt_flat(cnt_flat)
`ifdef LFU_LOCK_EN
    , .lock_mask(lock_mask)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [IDX_W-1:0] exp_q[$];
  int m_cnt [NUM_BUF];
  logic m_vld, m_age;
  logic [IDX_W-1:0] m_last;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_flat();
    logic [31:0] f = '0;
    for (int i = 0; i < NUM_BUF; i++) f[i*CNT_W +: CNT_W] = m_cnt[i][CNT_W-1:0];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_BUF; i++) m_cnt[i] = 0;
    m_vld = 1'b0; m_age = 1'b0; m_last = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    check_val("replc_vld", {31'd0, replc_vld}, {31'd0, m_vld});
    if (replc_vld) begin
      if (exp_q.size() == 0) check_val("unexpected_replc", 32'd1, 32'd0);
      else check_val("victim", {30'd0, buf_num_replc}, {30'd0, exp_q.pop_front()});
    end else begin
      check_val("victim_hold", {30'd0, buf_num_replc}, {30'd0, m_last});
    end
    check_val("aging_pulse", {31'd0, aging_pulse}, {31'd0, m_age});
    check_val("cnt_flat", {24'd0, cnt_flat}, model_flat());
  endtask

  // Drive one cycle, predict its effect, then check after the edge.
  task automatic drive_cycle(input logic rv, input logic [IDX_W-1:0] rb, input logic req);
    int nxt [NUM_BUF];
    logic found, rep;
    logic [IDX_W-1:0] vic;
    @(negedge clk);
    ref_vld = rv; ref_buf_numbr = rb; new_buf_req = req;
    found = 1'b0; vic = '0;
    for (int i = 0; i < NUM_BUF; i++)
      if (!lock_mask[i] && (!found || m_cnt[i] < m_cnt[vic])) begin
        vic = IDX_W'(i); found = 1'b1;
      end
`ifndef LFU_LOCK_EN
    if (lock_mask != '0) found = found;
`endif
    rep = req && found;
    if (rep) begin exp_q.push_back(vic); m_last = vic; end
    nxt = m_cnt;
    m_age = 1'b0;
    if (rv && !(rep && rb == vic)) begin
      if (m_cnt[rb] == MAXV) begin
        m_age = 1'b1;
        for (int j = 0; j < NUM_BUF; j++) nxt[j] = (j == rb) ? (MAXV / 2 + 1) : (m_cnt[j] / 2);
      end else begin
        nxt[rb] = m_cnt[rb] + 1;
      end
    end
    if (rep) nxt[vic] = 1;
    m_vld = rep;
    @(posedge clk);
    m_cnt = nxt;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ref_vld = 1'b0; new_buf_req = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();
  endtask

  task automatic refs(input logic [IDX_W-1:0] b, input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, b, 1'b0);
  endtask

  initial begin
    model_clear();
    lock_mask = '0;
    #12;
    check_val("reset_cnt", {24'd0, cnt_flat}, 32'd0);
    check_val("reset_vld", {31'd0, replc_vld}, 32'd0);
    do_reset();
    drive_cycle(1'b0, 2'd0, 1'b1);
    check_val("first_victim_cnt", {24'd0, cnt_flat}, 32'h01);

    // Mixed references then a request: {3,2,1,3}, victim 2.
    do_reset();
    refs(2'd0, 3); refs(2'd1, 2); refs(2'd3, 3); refs(2'd2, 1);
    drive_cycle(1'b0, 2'd0, 1'b1);
    check_val("mixed_cnt", {24'd0, cnt_flat}, 32'hDB);

    // Saturation aging: {3,2,1,3} + ref buf0 -> {2,1,0,1}.
    do_reset();
    refs(2'd0, 3); refs(2'd1, 2); refs(2'd2, 1); refs(2'd3, 3);
    drive_cycle(1'b1, 2'd0, 1'b0);
    check_val("aging_cnt", {24'd0, cnt_flat}, 32'h46);
    drive_cycle(1'b0, 2'd0, 1'b0);

    // Held request from all-zero.
    do_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 2'd0, 1'b1);
    check_val("held_cnt", {24'd0, cnt_flat}, 32'h55);
    drive_cycle(1'b0, 2'd0, 1'b0);

    // Same-cycle ref on the victim: replacement wins.
    do_reset();
    refs(2'd0, 3); refs(2'd1, 3); refs(2'd3, 2);
    drive_cycle(1'b1, 2'd2, 1'b1);
    check_val("ref_eq_victim_cnt", {24'd0, cnt_flat}, 32'h9F);

    // Same-cycle aging ref with a different victim: {0,3,3,3} -> {1,1,1,2}.
    do_reset();
    refs(2'd1, 3); refs(2'd2, 3); refs(2'd3, 3);
    drive_cycle(1'b1, 2'd3, 1'b1);
    check_val("ref_aging_victim_cnt", {24'd0, cnt_flat}, 32'h95);

    // Asynchronous reset between edges during a held request.
    drive_cycle(1'b1, 2'd1, 1'b1);
    drive_cycle(1'b0, 2'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_cnt", {24'd0, cnt_flat}, 32'd0);
    check_val("async_vld", {31'd0, replc_vld}, 32'd0);
    check_val("async_victim", {30'd0, buf_num_replc}, 32'd0);
    check_val("async_aging", {31'd0, aging_pulse}, 32'd0);
    model_clear();
    new_buf_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 2'd0, 1'b0);

`ifdef LFU_LOCK_EN
    do_reset();
    lock_mask = 4'b0001;
    drive_cycle(1'b0, 2'd0, 1'b1);
    check_val("lock_victim", {30'd0, buf_num_replc}, 32'd1);
    lock_mask = 4'b1111;
    drive_cycle(1'b0, 2'd0, 1'b1);
    check_val("lock_all_vld", {31'd0, replc_vld}, 32'd0);
    lock_mask = '0;
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
`ifdef LFU_LOCK_EN
      lock_mask = NUM_BUF'($urandom_range(0, 15));
`endif
      drive_cycle(1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, NUM_BUF - 1)),
                  1'($urandom_range(0, 3) == 0));
    end
    drive_cycle(1'b0, 2'd0, 1'b0);
    check_val("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
